// File: rtl/pipe_flow_ctrl.sv
// Control side of an enable/flush pipeline: per-stage valids, elastic ready chain, and flushes.
// Define PIPE_FLOW_CTRL_PERF_EN to build the stall/flush performance counters.
module pipe_flow_ctrl #(
  parameter int unsigned STAGES     = 4,
  parameter int unsigned FLUSH_HOLD = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic [STAGES-1:0]         stall_req,
  input  logic                      flush_req,
  input  logic [$clog2(STAGES)-1:0] flush_upto,
  output logic [STAGES-1:0]         stage_en,
  output logic [STAGES-1:0]         stage_flush,
  output logic [STAGES-1:0]         stage_valid,
  output logic                      flushing,
  output logic [CNT_W-1:0]          perf_stall_cnt,
  output logic [CNT_W-1:0]          perf_flush_cnt
);

  localparam int unsigned KW       = $clog2(STAGES);
  localparam logic [KW-1:0] LastIdx = KW'(STAGES - 1);
  localparam int unsigned HoldW    = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldInit = HoldW'(FLUSH_HOLD - 1);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e            state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [KW-1:0]     k_q, k_d;
  logic [STAGES-1:0] valid_q, valid_d;

  logic [STAGES:0]   ready;
  logic [STAGES-1:0] fmask;
  logic [STAGES-1:0] en;
  logic [KW-1:0]     k_in;
  logic [KW-1:0]     k_eff;
  logic              flush_active;
  logic              accept_in;

  // Out-of-range requests (non-power-of-2 depth) flush the whole pipe.
  always_comb begin
    k_in = (flush_upto > LastIdx) ? LastIdx : flush_upto;
  end

  always_comb begin
    k_eff = k_q;
    if (flush_req) begin
      k_eff = ((state_q == StFlush) && (k_q > k_in)) ? k_q : k_in;
    end
  end

  always_comb begin
    flush_active = flush_req || (state_q == StFlush);
    for (int i = 0; i < STAGES; i++) begin
      fmask[i] = flush_active && (KW'(i) <= k_eff);
    end
  end

  // Ready ripples from the output back to stage 0; an empty stage always accepts.
  always_comb begin
    ready[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      ready[i] = !stall_req[i] && (!valid_q[i] || ready[i+1]);
    end
  end

  always_comb begin
    en        = ready[STAGES-1:0] & ~fmask;
    in_ready  = ready[0] && !flush_active;
    accept_in = in_valid && in_ready;
    out_valid = valid_q[STAGES-1] && !fmask[STAGES-1];
  end

  // A stage fed from a flushed neighbour receives a bubble, never stale data.
  always_comb begin
    valid_d = valid_q;
    if (en[0]) begin
      valid_d[0] = accept_in;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (en[i]) begin
        valid_d[i] = valid_q[i-1] && !fmask[i-1];
      end
    end
    valid_d = valid_d & ~fmask;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    k_d     = k_q;
    if (flush_req) begin
      if (FLUSH_HOLD > 1) begin
        state_d = StFlush;
        hold_d  = HoldInit;
        k_d     = k_eff;
      end
    end else if (state_q == StFlush) begin
      if (hold_q <= HoldW'(1)) begin
        state_d = StRun;
        hold_d  = '0;
      end else begin
        hold_d = hold_q - HoldW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StRun;
      hold_q  <= '0;
      k_q     <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      k_q     <= k_d;
      valid_q <= valid_d;
    end
  end

  assign stage_en    = en;
  assign stage_flush = fmask;
  assign stage_valid = valid_q;
  assign flushing    = (state_q == StFlush);

`ifdef PIPE_FLOW_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (in_valid && !in_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_req && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed bench for pipe_flow_ctrl: one instance with FLUSH_HOLD=1, one with FLUSH_HOLD=3.
module tb_pipe_flow_ctrl;

  logic       clk;
  logic       rstn;
  logic       in_valid;
  logic       out_ready;
  logic [3:0] stall_req;
  logic       flush_req;
  logic [1:0] flush_upto;

  logic        d_in_ready, d_out_valid, d_flushing;
  logic [3:0]  d_en, d_flush, d_valid;
  logic [15:0] d_pstall, d_pflush;

  logic        h_in_ready, h_out_valid, h_flushing;
  logic [3:0]  h_en, h_flush, h_valid;
  logic [15:0] h_pstall, h_pflush;

  int checks = 0;
  int errors = 0;

  pipe_flow_ctrl #(.STAGES(4), .FLUSH_HOLD(1), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(d_in_ready),
    .out_valid(d_out_valid), .out_ready(out_ready), .stall_req(stall_req),
    .flush_req(flush_req), .flush_upto(flush_upto), .stage_en(d_en),
    .stage_flush(d_flush), .stage_valid(d_valid), .flushing(d_flushing),
    .perf_stall_cnt(d_pstall), .perf_flush_cnt(d_pflush)
  );

  pipe_flow_ctrl #(.STAGES(4), .FLUSH_HOLD(3), .CNT_W(16)) dut3 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(h_in_ready),
    .out_valid(h_out_valid), .out_ready(out_ready), .stall_req(stall_req),
    .flush_req(flush_req), .flush_upto(flush_upto), .stage_en(h_en),
    .stage_flush(h_flush), .stage_valid(h_valid), .flushing(h_flushing),
    .perf_stall_cnt(h_pstall), .perf_flush_cnt(h_pflush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stall_req = 4'b0000;
    flush_req = 1'b0; flush_upto = 2'd0;
    #12;
    check("rst_valid", d_valid, 4'b0000);
    check("rst_out_valid", d_out_valid, 1'b0);
    check("rst_flushing", d_flushing, 1'b0);
    check("rst_flush", d_flush, 4'b0000);
    check("rst_pstall", d_pstall, 16'd0);
    check("rst_pflush", d_pflush, 16'd0);
    rstn = 1'b1;

    // Single item walks through an empty pipe
    tick();
    in_valid = 1'b1; out_ready = 1'b1; #1;
    check("walk_in_ready", d_in_ready, 1'b1);
    check("walk_en", d_en, 4'b1111);
    tick(); in_valid = 1'b0;
    check("walk_v1", d_valid, 4'b0001);
    check("walk_ov1", d_out_valid, 1'b0);
    tick(); check("walk_v2", d_valid, 4'b0010);
    tick(); check("walk_v3", d_valid, 4'b0100);
    check("walk_ov3", d_out_valid, 1'b0);
    tick(); check("walk_v4", d_valid, 4'b1000);
    check("walk_ov4", d_out_valid, 1'b1);
    tick(); check("walk_drain", d_valid, 4'b0000);

    // Fill against a blocked output
    in_valid = 1'b1; out_ready = 1'b0;
    tick(); tick(); tick(); tick();
    check("fill_valid", d_valid, 4'b1111);
    #1;
    check("fill_in_ready", d_in_ready, 1'b0);
    check("fill_en", d_en, 4'b0000);
    check("fill_out_valid", d_out_valid, 1'b1);
    tick();
    check("fill_hold", d_valid, 4'b1111);
`ifdef PIPE_FLOW_CTRL_PERF_EN
    check("perf_stall", d_pstall, 16'd1);
`else
    check("perf_stall_off", d_pstall, 16'd0);
`endif
    out_ready = 1'b1; #1;
    check("pop_en", d_en, 4'b1111);
    check("pop_in_ready", d_in_ready, 1'b1);
    tick(); out_ready = 1'b0; in_valid = 1'b0;
    check("pop_valid", d_valid, 4'b1111);

    out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    check("drain_valid", d_valid, 4'b0000);

    // Build 1010, then bubble collapse under an output stall
    out_ready = 1'b0;
    in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    check("pat_valid", d_valid, 4'b1010);
    stall_req = 4'b1000; in_valid = 1'b1; #1;
    check("bub_en", d_en, 4'b0111);
    check("bub_in_ready", d_in_ready, 1'b1);
    tick();
    check("bub_valid", d_valid, 4'b1101);
    stall_req = 4'b0000; #1;
    check("bub2_en", d_en, 4'b0011);
    tick();
    check("bub2_valid", d_valid, 4'b1111);

    // Partial flush of stages 0..1 while the output drains
    in_valid = 1'b0; out_ready = 1'b1; flush_req = 1'b1; flush_upto = 2'd1; #1;
    check("fl_flush", d_flush, 4'b0011);
    check("fl_in_ready", d_in_ready, 1'b0);
    check("fl_en", d_en, 4'b1100);
    check("fl_out_valid", d_out_valid, 1'b1);
    tick(); flush_req = 1'b0; flush_upto = 2'd0; #1;
    check("fl_valid", d_valid, 4'b1000);
    check("fl_flush_off", d_flush, 4'b0000);
    check("fl_flushing", d_flushing, 1'b0);

    // Flush reaching the output stage masks out_valid
    flush_req = 1'b1; flush_upto = 2'd3; #1;
    check("flo_out_valid", d_out_valid, 1'b0);
    check("flo_flush", d_flush, 4'b1111);
    tick(); flush_req = 1'b0; flush_upto = 2'd0;
    check("flo_valid", d_valid, 4'b0000);

    // Async reset of the hold-3 instance while it is flushing
    check("h_pre_flushing", h_flushing, 1'b1);
    rstn = 1'b0; #1;
    check("h_rst_flushing", h_flushing, 1'b0);
    check("h_rst_valid", h_valid, 4'b0000);
    #1; rstn = 1'b1;
    tick();

    // Multi-cycle flush, extended and widened by a second request
    flush_req = 1'b1; flush_upto = 2'd0; #1;
    check("h_c0_flush", h_flush, 4'b0001);
    check("h_c0_flushing", h_flushing, 1'b0);
    check("h_c0_in_ready", h_in_ready, 1'b0);
    tick(); flush_req = 1'b0; #1;
    check("h_c1_flush", h_flush, 4'b0001);
    check("h_c1_flushing", h_flushing, 1'b1);
    tick(); flush_req = 1'b1; flush_upto = 2'd2; #1;
    check("h_c2_flush", h_flush, 4'b0111);
    check("h_c2_flushing", h_flushing, 1'b1);
    tick(); flush_req = 1'b0; flush_upto = 2'd0; #1;
    check("h_c3_flush", h_flush, 4'b0111);
    check("h_c3_flushing", h_flushing, 1'b1);
    tick();
    check("h_c4_flush", h_flush, 4'b0111);
    check("h_c4_flushing", h_flushing, 1'b1);
    tick();
    check("h_c5_flush", h_flush, 4'b0000);
    check("h_c5_flushing", h_flushing, 1'b0);
`ifdef PIPE_FLOW_CTRL_PERF_EN
    check("h_perf_flush", h_pflush, 16'd2);
`else
    check("h_perf_flush_off", h_pflush, 16'd0);
`endif

    // Fill, enter FLUSH, then reset mid-flush
    in_valid = 1'b1; out_ready = 1'b0;
    tick(); tick(); tick(); tick();
    check("h_fill_valid", h_valid, 4'b1111);
    in_valid = 1'b0; flush_req = 1'b1; flush_upto = 2'd0;
    tick(); flush_req = 1'b0;
    check("h_mid_flushing", h_flushing, 1'b1);
    check("h_mid_valid", h_valid, 4'b1110);
    rstn = 1'b0; #1;
    check("h_mr_valid", h_valid, 4'b0000);
    check("h_mr_flushing", h_flushing, 1'b0);
    check("h_mr_out_valid", h_out_valid, 1'b0);
    #1; rstn = 1'b1;
    tick();
    check("h_after_flush", h_flush, 4'b0000);
    check("h_after_flushing", h_flushing, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
- Control-side counterpart to the enable/flush pipeline data registers: generates the per-stage load enables and flush strobes that drive a chain of STAGES enable/flush registers.
- Tracks per-stage valid bits and runs a valid/ready elastic pipeline with bubble collapse and per-stage stall requests.
- Sequences single- or multi-cycle partial flushes (youngest stages first).
- Sits beside each datapath pipeline; data registers hold payload only.

Parameters:
STAGES, 4, number of pipeline stages; stage 0 is youngest, STAGES-1 is oldest/output (>=2)
FLUSH_HOLD, 1, cycles stage_flush stays asserted per flush request (>=1)
CNT_W, 16, width of the optional performance counters

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
in_valid  input  1  upstream has data for stage 0
in_ready  output  1  stage 0 can load this cycle
out_valid  output  1  stage STAGES-1 holds valid data
out_ready  input  1  downstream accepts output
stall_req  input  STAGES  bit i: stage i must hold this cycle
flush_req  input  1  flush request, one-cycle pulse or level
flush_upto  input  $clog2(STAGES)  flush stages 0..flush_upto inclusive
stage_en  output  STAGES  load enable to data register i
stage_flush  output  STAGES  flush strobe to data register i
stage_valid  output  STAGES  registered valid bit per stage
flushing  output  1  controller in FLUSH state
perf_stall_cnt  output  CNT_W  cycles with in_valid && !in_ready
perf_flush_cnt  output  CNT_W  accepted flush requests

Behaviour:
- Reset (rstn low, async): valid[]=0, state=RUN, hold counter=0, perf counters=0. After release: stage_flush=0, out_valid=0, flushing=0.
- Ready chain, evaluated combinationally oldest to youngest:
  - r[STAGES]=out_ready.
  - r[i] = !stall_req[i] && (!valid[i] || r[i+1]).
  - stage_en[i]=r[i], gated as described under FLUSH.
  - in_ready=r[0] && !flushing.
  - out_valid=valid[STAGES-1] && !(flush covering STAGES-1 this cycle).
- Valid update: if stage_en[i], valid[i] <= valid[i-1] (in_valid && in_ready for i=0); otherwise valid[i] holds. Latency through an empty, unstalled pipe is STAGES cycles from in_valid&&in_ready to out_valid.
- Bubble collapse: an invalid stage loads even when downstream is stalled.
- Flush, cycle of an accepted flush_req with k=flush_upto:
  - stage_flush[0..k]=1.
  - valid[0..k] <= 0, overriding any load.
  - If stage k+1 loads from stage k in that cycle, valid[k+1] <= 0 (bubble, never stale data).
  - in_ready=0.
  - If FLUSH_HOLD>1: enter FLUSH with counter=FLUSH_HOLD-1.
- FLUSH state:
  - stage_flush[0..k_latched] stays 1 and those valids are held 0.
  - in_ready=0; flushing=1.
  - Stages above k_latched keep flowing normally.
  - Counter decrements each cycle; returns to RUN when it reaches 0 (flushing low in the RUN cycle).
- flush_req during FLUSH: counter reloads to FLUSH_HOLD-1 and k_latched <= max(k_latched, flush_upto).
- flush_upto >= STAGES (non-power-of-2 STAGES): clamped to STAGES-1.
- Level-held flush_req is re-accepted every cycle.
- Async reset mid-flush: immediate return to RUN, all valids cleared.

Optional Feature:
- Macro PIPE_FLOW_CTRL_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle with in_valid && !in_ready.
  - perf_flush_cnt increments per accepted flush_req cycle.
  - Both saturate at 2^CNT_W-1 and reset to 0.
- Undefined: counter logic is absent and both ports are tied to 0.

Test Plan:
- Reset then in_valid=1 for 1 cycle, out_ready=1, no stalls -> stage_valid walks 0001,0010,0100,1000; out_valid=1 exactly on cycle 4 after acceptance.
- Fill 4 stages with out_ready=0 -> in_ready=0 once stage_valid=1111; raise out_ready for 1 cycle -> stage_en=1111, in_ready=1, one item exits.
- stage_valid=1010, stall_req[3]=1, out_ready=0 -> stage_en=0111 (bubble collapse into stages 0 and 2), stage_valid becomes 1101 with in_valid=1.
- stage_valid=1111, out_ready=1, flush_req with flush_upto=1 -> stage_flush=0011 for 1 cycle; next stage_valid=1000 (stage 2 received a bubble); in_ready=0 during the flush cycle.
- FLUSH_HOLD=3, flush_upto=0, second flush_req with flush_upto=2 at hold cycle 2 -> stage_flush=0111 for 3 further cycles, flushing=1 throughout, then 0; with PIPE_FLOW_CTRL_PERF_EN, perf_flush_cnt=2.
- Assert rstn low mid-FLUSH with stage_valid=1111 -> immediately stage_valid=0000, flushing=0, stage_flush=0 after release.
